// File: rtl/pc_sequencer_if.sv
// Control/status bundle between decoder/ALU flags and the PC sequencer.
// master drives decoded control, slave (the sequencer) returns PC and status.
interface pc_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic              BranchTaken;
    logic              Jump;
    logic              JumpReg;
    logic [ADDR_W-1:0] BranchOffset;
    logic [ADDR_W-1:0] JumpTarget;
    logic [ADDR_W-1:0] RegTarget;
    logic              MemOp;
    logic              InWait;
    logic              InValid;
    logic              Halt;
    logic              Resume;
    logic [ADDR_W-1:0] PC;
    logic              Commit;
    logic [2:0]        State;
    logic              Halted;

    modport master (
        output BranchTaken, Jump, JumpReg, BranchOffset, JumpTarget, RegTarget,
        output MemOp, InWait, InValid, Halt, Resume,
        input  PC, Commit, State, Halted
    );

    modport slave (
        input  BranchTaken, Jump, JumpReg, BranchOffset, JumpTarget, RegTarget,
        input  MemOp, InWait, InValid, Halt, Resume,
        output PC, Commit, State, Halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-address controller for the instruction-fetch PC: selects sequential/branch/jump
// targets, holds the PC for memory waits, user input and halt, and issues Commit.
module pc_sequencer #(
    parameter int ADDR_W      = 11,
    parameter int WAIT_CYCLES = 2,
    parameter int RESET_ADDR  = 0
) (
    input  logic            Clock,
    input  logic            Reset,
    pc_sequencer_if.slave   bus
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_ADDR);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_MEMWAIT = 3'd2,
        ST_INPUT   = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               halted_reg;
    logic               commit_next;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_branch;

    // Both targets wrap modulo 2^ADDR_W by plain truncation.
    assign pc_inc    = pc_reg + ADDR_W'(1);
    assign pc_branch = pc_inc + bus.BranchOffset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg  <= ST_INIT;
            pc_reg     <= RST_PC;
            cnt_reg    <= '0;
            halted_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            cnt_reg    <= cnt_next;
            halted_reg <= (state_next == ST_HALT);
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        cnt_next    = cnt_reg;
        commit_next = 1'b0;

        case (state_reg)
            ST_INIT: begin
                state_next = ST_RUN;
            end

            ST_RUN: begin
                if (bus.Halt) begin
                    state_next = ST_HALT;
                end else if (bus.InWait && !bus.InValid) begin
                    state_next = ST_INPUT;
                end else if (bus.InWait) begin
                    commit_next = 1'b1;
                    pc_next     = pc_inc;
                end else if (bus.MemOp) begin
                    // A memory op always advances sequentially, even with a taken branch flag.
                    if (WAIT_CYCLES > 0) begin
                        state_next = ST_MEMWAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        commit_next = 1'b1;
                        pc_next     = pc_inc;
                    end
                end else if (bus.JumpReg) begin
                    commit_next = 1'b1;
                    pc_next     = bus.RegTarget;
                end else if (bus.Jump) begin
                    commit_next = 1'b1;
                    pc_next     = bus.JumpTarget;
                end else if (bus.BranchTaken) begin
                    commit_next = 1'b1;
                    pc_next     = pc_branch;
                end else begin
                    commit_next = 1'b1;
                    pc_next     = pc_inc;
                end
            end

            ST_MEMWAIT: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg <= CNT_ONE) begin
                    commit_next = 1'b1;
                    pc_next     = pc_inc;
                    state_next  = ST_RUN;
                end
            end

            ST_INPUT: begin
                if (bus.InValid) begin
                    commit_next = 1'b1;
                    pc_next     = pc_inc;
                    state_next  = ST_RUN;
                end
            end

            ST_HALT: begin
                // The halt instruction retires without a Commit when resumed.
                if (bus.Resume) begin
                    pc_next    = pc_inc;
                    state_next = ST_RUN;
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    assign bus.PC     = pc_reg;
    assign bus.Commit = commit_next & ~Reset;
    assign bus.State  = state_reg;
    assign bus.Halted = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: two sequencers (WAIT_CYCLES=2 and 0) share stimulus and are
// checked against directed expectations and an instruction-level reference model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        bt, jmp, jreg, mem, inw, inv, hlt, res;
    logic [10:0] boff, jtgt, rtgt;

    pc_sequencer_if #(.ADDR_W(11)) bus_w2 ();
    pc_sequencer_if #(.ADDR_W(11)) bus_w0 ();

    assign bus_w2.BranchTaken  = bt;
    assign bus_w2.Jump         = jmp;
    assign bus_w2.JumpReg      = jreg;
    assign bus_w2.BranchOffset = boff;
    assign bus_w2.JumpTarget   = jtgt;
    assign bus_w2.RegTarget    = rtgt;
    assign bus_w2.MemOp        = mem;
    assign bus_w2.InWait       = inw;
    assign bus_w2.InValid      = inv;
    assign bus_w2.Halt         = hlt;
    assign bus_w2.Resume       = res;

    assign bus_w0.BranchTaken  = bt;
    assign bus_w0.Jump         = jmp;
    assign bus_w0.JumpReg      = jreg;
    assign bus_w0.BranchOffset = boff;
    assign bus_w0.JumpTarget   = jtgt;
    assign bus_w0.RegTarget    = rtgt;
    assign bus_w0.MemOp        = mem;
    assign bus_w0.InWait       = inw;
    assign bus_w0.InValid      = inv;
    assign bus_w0.Halt         = hlt;
    assign bus_w0.Resume       = res;

    pc_sequencer #(.ADDR_W(11), .WAIT_CYCLES(2), .RESET_ADDR(0)) dut_w2 (
        .Clock (clk),
        .Reset (reset),
        .bus   (bus_w2)
    );

    pc_sequencer #(.ADDR_W(11), .WAIT_CYCLES(0), .RESET_ADDR(0)) dut_w0 (
        .Clock (clk),
        .Reset (reset),
        .bus   (bus_w0)
    );

    // index 0 = WAIT_CYCLES 2, index 1 = WAIT_CYCLES 0
    logic [10:0] o_pc     [2];
    logic        o_commit [2];
    logic [2:0]  o_state  [2];
    logic        o_halted [2];
    assign o_pc[0] = bus_w2.PC;         assign o_pc[1] = bus_w0.PC;
    assign o_commit[0] = bus_w2.Commit; assign o_commit[1] = bus_w0.Commit;
    assign o_state[0] = bus_w2.State;   assign o_state[1] = bus_w0.State;
    assign o_halted[0] = bus_w2.Halted; assign o_halted[1] = bus_w0.Halted;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: spec states 0..4, memory cycles still owed by the current load/store.
    int wc [2] = '{2, 0};
    int m_pc [2], m_st [2], m_left [2];
    int n_pc [2], n_st [2], n_left [2];
    bit e_commit [2];

    task automatic model_eval();
        for (int d = 0; d < 2; d++) begin
            n_pc[d] = m_pc[d]; n_st[d] = m_st[d]; n_left[d] = m_left[d]; e_commit[d] = 1'b0;
            if (reset) begin
                n_pc[d] = 0; n_st[d] = 0; n_left[d] = 0;
            end else if (m_st[d] == 0) begin
                n_st[d] = 1;
            end else if (m_st[d] == 1) begin
                if (hlt) n_st[d] = 4;
                else if (inw && !inv) n_st[d] = 3;
                else if (!inw && mem && wc[d] > 0) begin
                    n_st[d] = 2; n_left[d] = wc[d];
                end else begin
                    e_commit[d] = 1'b1;
                    if (inw || mem) n_pc[d] = m_pc[d] + 1;
                    else if (jreg)  n_pc[d] = int'(rtgt);
                    else if (jmp)   n_pc[d] = int'(jtgt);
                    else if (bt)    n_pc[d] = m_pc[d] + 1 + int'($signed(boff));
                    else            n_pc[d] = m_pc[d] + 1;
                end
            end else if (m_st[d] == 2) begin
                n_left[d] = m_left[d] - 1;
                if (n_left[d] == 0) begin
                    e_commit[d] = 1'b1; n_pc[d] = m_pc[d] + 1; n_st[d] = 1;
                end
            end else if (m_st[d] == 3) begin
                if (inv) begin
                    e_commit[d] = 1'b1; n_pc[d] = m_pc[d] + 1; n_st[d] = 1;
                end
            end else begin
                if (res) begin
                    n_pc[d] = m_pc[d] + 1; n_st[d] = 1;
                end
            end
            n_pc[d] = n_pc[d] & 32'h7FF;
        end
    endtask

    task automatic cyc();
        model_eval();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = n_pc[d]; m_st[d] = n_st[d]; m_left[d] = n_left[d];
        end
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic clear_inputs();
        bt = 0; jmp = 0; jreg = 0; mem = 0; inw = 0; inv = 0; hlt = 0; res = 0;
        boff = '0; jtgt = '0; rtgt = '0;
    endtask

    task automatic go_to(input logic [10:0] a);
        jmp = 1'b1; jtgt = a;
        cyc();
        jmp = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        cyc(); cyc();
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_commit[d] !== 1'b0 || o_state[d] !== 3'd0) begin
                miscompares++;
                $display("FAIL reset_hold d%0d: commit=%0b state=%0d, required commit=0 state=0", d, o_commit[d], o_state[d]);
            end
        end
        reset = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'd0 || o_state[d] !== 3'd0 || o_commit[d] !== 1'b0 || o_halted[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL init d%0d: pc=%0h state=%0d commit=%0b halted=%0b, required 0/0/0/0", d, o_pc[d], o_state[d], o_commit[d], o_halted[d]);
            end
        end
        cyc();
        for (int k = 0; k < 4; k++) begin
            settle();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (o_pc[d] !== 11'(k) || o_commit[d] !== 1'b1 || o_state[d] !== 3'd1) begin
                    miscompares++;
                    $display("FAIL seq_step d%0d: pc=%0h commit=%0b state=%0d, required pc=%0h commit=1 state=1", d, o_pc[d], o_commit[d], o_state[d], k);
                end
            end
            cyc();
        end
    endtask

    task automatic test_branch_jump();
        clear_inputs();
        go_to(11'd5);
        bt = 1'b1; boff = 11'h7FD;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'd5 || o_commit[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL branch_src d%0d: pc=%0h commit=%0b, required pc=5 commit=1", d, o_pc[d], o_commit[d]);
            end
        end
        cyc();
        bt = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'd3) begin
                miscompares++;
                $display("FAIL branch_back d%0d: pc=%0h, required 3", d, o_pc[d]);
            end
        end
        go_to(11'h7FF);
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'h7FF) begin
                miscompares++;
                $display("FAIL jump_top d%0d: pc=%0h, required 7ff", d, o_pc[d]);
            end
        end
        cyc();
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'h000 || o_commit[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL pc_wrap d%0d: pc=%0h commit=%0b, required pc=0 commit=1", d, o_pc[d], o_commit[d]);
            end
        end
        jreg = 1'b1; rtgt = 11'h155; jmp = 1'b1; jtgt = 11'h2AA; bt = 1'b1; boff = 11'd9;
        cyc();
        clear_inputs();
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'h155) begin
                miscompares++;
                $display("FAIL jreg_priority d%0d: pc=%0h, required 155", d, o_pc[d]);
            end
        end
    endtask

    task automatic test_memop();
        int pc_e [2][3] = '{'{8, 8, 8}, '{8, 9, 10}};
        int cm_e [2][3] = '{'{0, 0, 1}, '{1, 1, 1}};
        int st_e [2][3] = '{'{1, 2, 2}, '{1, 1, 1}};
        int pc_after [2] = '{9, 11};
        clear_inputs();
        go_to(11'd8);
        mem = 1'b1; bt = 1'b1; boff = 11'd5;
        for (int i = 0; i < 3; i++) begin
            settle();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (o_pc[d] !== 11'(pc_e[d][i]) || o_commit[d] !== 1'(cm_e[d][i]) || o_state[d] !== 3'(st_e[d][i])) begin
                    miscompares++;
                    $display("FAIL memop c%0d d%0d: pc=%0h commit=%0b state=%0d, required pc=%0h commit=%0d state=%0d",
                             i, d, o_pc[d], o_commit[d], o_state[d], pc_e[d][i], cm_e[d][i], st_e[d][i]);
                end
            end
            cyc();
        end
        clear_inputs();
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'(pc_after[d])) begin
                miscompares++;
                $display("FAIL memop_after d%0d: pc=%0h, required %0h", d, o_pc[d], pc_after[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pc_after [2] = '{22, 26};
        int commits [2];
        clear_inputs();
        go_to(11'd20);
        mem = 1'b1;
        commits = '{0, 0};
        for (int i = 0; i < 6; i++) begin
            settle();
            for (int d = 0; d < 2; d++) commits[d] += int'(o_commit[d]);
            cyc();
        end
        mem = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'(pc_after[d]) || commits[d] != pc_after[d] - 20) begin
                miscompares++;
                $display("FAIL back_to_back d%0d: pc=%0h commits=%0d, required pc=%0h commits=%0d", d, o_pc[d], commits[d], pc_after[d], pc_after[d] - 20);
            end
        end
    endtask

    task automatic test_input();
        clear_inputs();
        go_to(11'd4);
        inw = 1'b1; inv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (o_pc[d] !== 11'd4 || o_commit[d] !== 1'b0 || o_state[d] !== ((i == 0) ? 3'd1 : 3'd3)) begin
                    miscompares++;
                    $display("FAIL input_wait c%0d d%0d: pc=%0h commit=%0b state=%0d, required pc=4 commit=0 state=%0d",
                             i, d, o_pc[d], o_commit[d], o_state[d], (i == 0) ? 1 : 3);
                end
            end
            cyc();
        end
        inv = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_commit[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL input_valid d%0d: commit=%0b, required 1", d, o_commit[d]);
            end
        end
        cyc();
        clear_inputs();
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'd5 || o_state[d] !== 3'd1) begin
                miscompares++;
                $display("FAIL input_done d%0d: pc=%0h state=%0d, required pc=5 state=1", d, o_pc[d], o_state[d]);
            end
        end
    endtask

    task automatic test_halt();
        clear_inputs();
        go_to(11'd10);
        hlt = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_commit[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_nocommit d%0d: commit=%0b, required 0", d, o_commit[d]);
            end
        end
        cyc();
        for (int i = 0; i < 20; i++) begin
            hlt = 1'($urandom); jmp = 1'($urandom); bt = 1'($urandom); mem = 1'($urandom);
            jtgt = 11'($urandom); boff = 11'($urandom);
            settle();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (o_halted[d] !== 1'b1 || o_pc[d] !== 11'd10 || o_state[d] !== 3'd4 || o_commit[d] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL halt_hold c%0d d%0d: halted=%0b pc=%0h state=%0d commit=%0b, required 1/a/4/0",
                             i, d, o_halted[d], o_pc[d], o_state[d], o_commit[d]);
                end
            end
            cyc();
        end
        clear_inputs();
        res = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_commit[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL resume_nocommit d%0d: commit=%0b, required 0", d, o_commit[d]);
            end
        end
        cyc();
        res = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'd11 || o_halted[d] !== 1'b0 || o_state[d] !== 3'd1) begin
                miscompares++;
                $display("FAIL resume d%0d: pc=%0h halted=%0b state=%0d, required pc=b halted=0 state=1", d, o_pc[d], o_halted[d], o_state[d]);
            end
        end
        hlt = 1'b1; jmp = 1'b1; jtgt = 11'h123;
        cyc();
        clear_inputs();
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_state[d] !== 3'd4 || o_pc[d] !== 11'd11 || o_halted[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_jump d%0d: state=%0d pc=%0h halted=%0b, required state=4 pc=b halted=1", d, o_state[d], o_pc[d], o_halted[d]);
            end
        end
        res = 1'b1;
        cyc();
        res = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'd12) begin
                miscompares++;
                $display("FAIL resume2 d%0d: pc=%0h, required c", d, o_pc[d]);
            end
        end
    endtask

    task automatic test_reset_midwait();
        int w0_pc_e [3] = '{0, 1, 2};
        int cm_e [3] = '{0, 0, 1};
        clear_inputs();
        go_to(11'd8);
        mem = 1'b1;
        cyc();
        mem = 1'b0;
        settle();
        vectors++;
        if (o_state[0] !== 3'd2) begin
            miscompares++;
            $display("FAIL midwait_state: state=%0d, required 2", o_state[0]);
        end
        reset = 1'b1;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_commit[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_commit d%0d: commit=%0b, required 0", d, o_commit[d]);
            end
        end
        cyc();
        reset = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (o_pc[d] !== 11'd0 || o_state[d] !== 3'd0 || o_commit[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL midwait_reset d%0d: pc=%0h state=%0d commit=%0b, required 0/0/0", d, o_pc[d], o_state[d], o_commit[d]);
            end
        end
        cyc();
        mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++;
            if (o_pc[0] !== 11'd0 || o_commit[0] !== 1'(cm_e[i])) begin
                miscompares++;
                $display("FAIL wait_after_reset c%0d: pc=%0h commit=%0b, required pc=0 commit=%0d", i, o_pc[0], o_commit[0], cm_e[i]);
            end
            vectors++;
            if (o_pc[1] !== 11'(w0_pc_e[i]) || o_commit[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL w0_after_reset c%0d: pc=%0h commit=%0b, required pc=%0h commit=1", i, o_pc[1], o_commit[1], w0_pc_e[i]);
            end
            cyc();
        end
        clear_inputs();
        settle();
        vectors++;
        if (o_pc[0] !== 11'd1) begin
            miscompares++;
            $display("FAIL wait_after_reset_pc: pc=%0h, required 1", o_pc[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            hlt   = ($urandom_range(0, 15) == 0);
            res   = ($urandom_range(0, 3) == 0);
            inw   = ($urandom_range(0, 9) == 0);
            inv   = ($urandom_range(0, 2) == 0);
            mem   = ($urandom_range(0, 5) == 0);
            jreg  = ($urandom_range(0, 7) == 0);
            jmp   = ($urandom_range(0, 7) == 0);
            bt    = ($urandom_range(0, 3) == 0);
            boff  = 11'($urandom);
            jtgt  = 11'($urandom);
            rtgt  = 11'($urandom);
            settle();
            for (int d = 0; d < 2; d++) begin
                vectors++;
                if (o_pc[d] !== 11'(m_pc[d]) || o_state[d] !== 3'(m_st[d]) ||
                    o_commit[d] !== e_commit[d] || o_halted[d] !== (m_st[d] == 4)) begin
                    miscompares++;
                    $display("FAIL random c%0d d%0d: pc=%0h state=%0d commit=%0b halted=%0b, required pc=%0h state=%0d commit=%0b halted=%0b",
                             i, d, o_pc[d], o_state[d], o_commit[d], o_halted[d],
                             m_pc[d], m_st[d], e_commit[d], (m_st[d] == 4));
                end
            end
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_pc[d] = 0; m_st[d] = 0; m_left[d] = 0;
        end
        @(negedge clk);
        test_reset();
        test_branch_jump();
        test_memop();
        test_back_to_back();
        test_input();
        test_halt();
        test_reset_midwait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-address controller for the 11-bit instruction-fetch PC.
- Each cycle it selects the next PC from sequential, branch, jump or jump-register sources, and holds the PC for multi-cycle memory ops, user-input waits and halt.
- Issues the per-instruction Commit strobe that gates register-file and data-memory writes.
- Sits between the instruction decoder/ALU flags and the instruction memory address.

Parameters:
ADDR_W, 11, PC / instruction address width
WAIT_CYCLES, 2, extra hold cycles for a memory instruction (0 = single-cycle)
RESET_ADDR, 0, PC value loaded on reset

Ports:
Clock  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
BranchTaken  in  1  conditional branch decoded and condition true
Jump  in  1  absolute jump decoded
JumpReg  in  1  jump-to-register decoded
BranchOffset  in  ADDR_W  signed two's-complement word offset
JumpTarget  in  ADDR_W  absolute jump address
RegTarget  in  ADDR_W  register value for JumpReg
MemOp  in  1  current instruction is a load/store
InWait  in  1  current instruction is a user-input instruction
InValid  in  1  user input confirmed (level)
Halt  in  1  current instruction is halt
Resume  in  1  leave HALT (level)
PC  out  ADDR_W  current instruction address (registered)
Commit  out  1  current instruction completes this cycle (combinational)
State  out  3  FSM state: INIT=0, RUN=1, MEMWAIT=2, INPUT=3, HALT=4
Halted  out  1  high while in HALT (registered)

Behaviour:
- Reset (sampled at the edge) from any state, including mid-wait: PC=RESET_ADDR, State=INIT, wait counter=0, Halted=0. Commit is forced 0 while Reset is high.
- INIT: one cycle, PC held, Commit=0. Then go to RUN. The first instruction is fetched from RESET_ADDR exactly once.
- RUN uses this priority (highest first):
  - Halt: go to HALT, PC held, Commit=0.
  - InWait & !InValid: go to INPUT, PC held, Commit=0.
  - InWait & InValid: Commit=1, PC<=PC+1, stay in RUN.
  - MemOp with WAIT_CYCLES>0: go to MEMWAIT, counter<=WAIT_CYCLES, PC held, Commit=0.
  - MemOp with WAIT_CYCLES=0: Commit=1, PC<=PC+1.
  - JumpReg: PC<=RegTarget, Commit=1.
  - Jump: PC<=JumpTarget, Commit=1.
  - BranchTaken: PC<=PC+1+BranchOffset, Commit=1.
  - Otherwise: PC<=PC+1, Commit=1.
- MEMWAIT:
  - Counter decrements each cycle.
  - While counter>1: Commit=0, PC held.
  - When counter==1: Commit=1, PC<=PC+1, return to RUN.
  - Total occupancy of a memory instruction is WAIT_CYCLES+1 cycles with exactly one Commit.
- INPUT: hold PC with Commit=0 until InValid=1. In that cycle Commit=1, PC<=PC+1, go to RUN.
- HALT: Halted=1, PC held, Commit=0. When Resume=1: PC<=PC+1, Halted<=0, go to RUN. The halt instruction never commits.
- Branch, jump and register fields are ignored outside RUN.
- Arithmetic: all PC math is modulo 2^ADDR_W. PC+1 at 0x7FF wraps to 0x000. Branch target is truncated to ADDR_W bits, with no overflow flag.
- Simultaneous inputs: the priority list above resolves them. A memory instruction with a taken branch flag still advances sequentially. Reset overrides everything.
- Commit is a pure function of State, counter and inputs; there is no registered delay.

Test Plan:
- Reset high for 2 cycles, then low: PC=0 in INIT for 1 cycle with Commit=0. In RUN with no control inputs, PC steps 0,1,2,3 with Commit=1 every cycle.
- PC=5, BranchTaken=1, BranchOffset=-3: next PC=3. Then Jump=1, JumpTarget=0x7FF → PC=0x7FF; next sequential PC=0x000 (wrap).
- WAIT_CYCLES=2, MemOp at PC=8: PC=8 for 3 cycles, Commit pattern 0,0,1, then PC=9. Repeat with WAIT_CYCLES=0: 1 cycle, Commit=1.
- InWait at PC=4 with InValid low for 5 cycles: State=INPUT, PC=4, Commit=0. InValid high → Commit=1, PC=5.
- Halt at PC=10: Halted=1, PC stays 10 for 20 cycles. Resume → PC=11, Halted=0. Also Halt+Jump together → HALT.
- Reset asserted on the middle cycle of MEMWAIT at PC=8: next PC=0, State=INIT, no Commit, counter cleared. The following MemOp waits the full WAIT_CYCLES.
